// File: rtl/adder.sv
// Parameterised two's-complement ripple-carry adder with registered outputs.
// The core is an explicit chain of full-adder cells. The sum, the carry-out
// and the signed-overflow flag are captured together on every rising edge,
// giving a fixed latency of one cycle.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // carry_s[i] is the carry into bit i. carry_s[0] is the external carry-in.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             overflow_s;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             overflow_r;

    assign carry_s[0] = cin;

    // Ripple chain of full-adder cells, one cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        adder_fa u_fa (
            .a_bit   (a[i]),
            .b_bit   (b[i]),
            .c_in    (carry_s[i]),
            .s_bit   (sum_s[i]),
            .c_out   (carry_s[i+1])
        );
    end

    // Signed overflow is the carry into the MSB differing from the carry out
    // of the MSB. For WIDTH=1 the carry into the MSB is cin itself.
    assign overflow_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];

    // Output register: capture every edge with no enable, and clear asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r      <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            sum_r      <= sum_s;
            cout_r     <= carry_s[WIDTH];
            overflow_r <= overflow_s;
        end
    end

    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;

endmodule

// Single-bit full adder cell used by the ripple chain.
module adder_fa (
    input  logic a_bit,
    input  logic b_bit,
    input  logic c_in,
    output logic s_bit,
    output logic c_out
);

    assign s_bit = a_bit ^ b_bit ^ c_in;
    assign c_out = (a_bit & b_bit) | (a_bit & c_in) | (b_bit & c_in);

endmodule

// File: tb/tb_adder.sv
// Directed testbench for the adder: an 8-bit instance for the arithmetic and
// pipelining checks, and an 11-bit instance used as a compare-by-subtract.
module tb_adder;

    logic        clk;
    logic        reset;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;
    logic [10:0] a11;
    logic [10:0] b11;
    logic        cin11;
    logic [10:0] sum11;
    logic        cout11;
    logic        ovf11;

    int errors;
    int checks;

    adder #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .a        (a8),
        .b        (b8),
        .cin      (cin8),
        .sum      (sum8),
        .cout     (cout8),
        .overflow (ovf8)
    );

    adder #(.WIDTH(11)) u_dut11 (
        .clk      (clk),
        .reset    (reset),
        .a        (a11),
        .b        (b11),
        .cin      (cin11),
        .sum      (sum11),
        .cout     (cout11),
        .overflow (ovf11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an 8-bit vector, pass one rising edge and check all three outputs.
    task automatic vec8(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec, input logic eo);
        a8 = va; b8 = vb; cin8 = vc;
        @(posedge clk); #1;
        checks++;
        if ({sum8, cout8, ovf8} !== {es, ec, eo}) begin
            errors++;
            $display("FAIL %s: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     name, sum8, cout8, ovf8, es, ec, eo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0;
        a11 = 11'h000; b11 = 11'h000; cin11 = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sum8, cout8, ovf8} !== 10'h000) begin
                errors++;
                $display("FAIL reset_hold: sum=%h cout=%b ovf=%b, expected all zero", sum8, cout8, ovf8);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sum8, cout8, ovf8} !== {8'h66, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: sum=%h cout=%b ovf=%b, expected sum=66 cout=0 ovf=0", sum8, cout8, ovf8);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({sum8, cout8, ovf8} !== 10'h000) begin
            errors++;
            $display("FAIL reset_async: sum=%h cout=%b ovf=%b, expected all zero", sum8, cout8, ovf8);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_plain_add();
        vec8("add_cin0", 8'h23, 8'h0C, 1'b0, 8'h2F, 1'b0, 1'b0);
        vec8("add_cin1", 8'h23, 8'h0C, 1'b1, 8'h30, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        vec8("ovf_pos",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        vec8("ovf_neg",  8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
        vec8("no_ovf_mixed", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        vec8("wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        vec8("all_ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        vec8("zero",     8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_compare();
        logic [9:0] ta [3];
        logic [9:0] tb [3];
        logic [10:0] es [3];
        ta[0] = 10'd36; tb[0] = 10'd33; es[0] = 11'h003;
        ta[1] = 10'd1;  tb[1] = 10'd0;  es[1] = 11'h001;
        ta[2] = 10'd12; tb[2] = 10'd35; es[2] = 11'h7E9;
        for (int i = 0; i < 3; i++) begin
            a11 = {1'b0, ta[i]};
            b11 = {1'b1, ~tb[i]};
            cin11 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (sum11 !== es[i]) begin
                errors++;
                $display("FAIL compare_%0d: sum=%h, expected %h", i, sum11, es[i]);
            end
            checks++;
            if (sum11[10] !== (ta[i] < tb[i])) begin
                errors++;
                $display("FAIL compare_msb_%0d: msb=%b, expected %b", i, sum11[10], ta[i] < tb[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va, vb;
        logic       vc;
        logic [8:0] full;
        logic [9:0] exp_r;
        logic [9:0] exp_s;
        exp_r = {sum8, cout8, ovf8};
        for (int i = 0; i < 16; i++) begin
            va = 8'($urandom); vb = 8'($urandom); vc = 1'($urandom);
            full = {1'b0, va} + {1'b0, vb} + {8'h00, vc};
            exp_s = {full[7:0], full[8], (va[7] == vb[7]) && (full[7] != va[7])};
            a8 = va; b8 = vb; cin8 = vc;
            // The previous result must still be held before the edge.
            #2;
            checks++;
            if ({sum8, cout8, ovf8} !== exp_r) begin
                errors++;
                $display("FAIL pipe_hold_%0d: got %h, expected %h", i, {sum8, cout8, ovf8}, exp_r);
            end
            if (i == 8) begin
                reset = 1'b1;
                #1;
                checks++;
                if ({sum8, cout8, ovf8} !== 10'h000) begin
                    errors++;
                    $display("FAIL pipe_reset: got %h, expected 000", {sum8, cout8, ovf8});
                end
                @(posedge clk); #1;
                checks++;
                if ({sum8, cout8, ovf8} !== 10'h000) begin
                    errors++;
                    $display("FAIL pipe_reset_edge: got %h, expected 000", {sum8, cout8, ovf8});
                end
                reset = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if ({sum8, cout8, ovf8} !== exp_s) begin
                errors++;
                $display("FAIL pipe_%0d: got %h, expected %h (a=%h b=%h cin=%b)",
                         i, {sum8, cout8, ovf8}, exp_s, va, vb, vc);
            end
            exp_r = exp_s;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_plain_add();
        test_overflow();
        test_wrap();
        test_compare();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- Parameterised two's-complement ripple-carry adder with carry-in and registered outputs.
- Computes a + b + cin and produces sum, carry-out and signed-overflow flag.
- Primitive arithmetic building block. Comparators use it as a subtractor: extend operands, invert b, set cin=1, then inspect the sum MSB.

Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all outputs update on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all output registers.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B, two's complement or unsigned.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1 (unsigned overflow).
- overflow  output  1  registered signed overflow.

Behaviour:
- Combinational core:
  - Per-bit full adders, bit i: s_i = a_i ^ b_i ^ c_i, c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i, with c_0 = cin.
  - Built as a generate loop of full-adder cells, not a behavioural "+".
- Output register:
  - sum, cout and overflow are captured on every rising clk edge. There is no enable.
  - Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
  - Throughput is one result per cycle. Inputs may change every cycle.
- Flags:
  - cout = c_WIDTH.
  - overflow = c_WIDTH ^ c_{WIDTH-1}, i.e. signed overflow: operands of the same sign produce a result of the opposite sign.
  - For WIDTH=1, overflow = c_1 ^ cin.
- Reset:
  - While reset=1, sum=0, cout=0 and overflow=0, immediately and independent of clk.
  - On deassertion, the first valid result appears after the next rising edge.
  - Reset asserted mid-stream discards the in-flight result. There is no partial update.
- Boundaries:
  - Wrap-around is modulo 2^WIDTH. No saturation.
  - a=b=all-ones, cin=1 gives sum=all-ones, cout=1.
- Unused outputs may be left unconnected by parents without affecting sum.
- No X propagation from an unconnected cout or overflow. cin must be driven.

Test Plan:
1. Reset: drive reset=1 with a=0x55, b=0x11 and toggle clk → sum=0x00, cout=0, overflow=0 at all times. Assert reset between edges → outputs clear immediately.
2. Plain add, WIDTH=8: a=0x23, b=0x0C, cin=0 → after next edge sum=0x2F, cout=0, overflow=0. Same with cin=1 → sum=0x30.
3. Signed overflow, WIDTH=8:
   - a=0x7F, b=0x01, cin=0 → sum=0x80, overflow=1, cout=0.
   - a=0x80, b=0xFF → sum=0x7F, overflow=1, cout=1.
4. Unsigned wrap, WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0.
5. Compare-by-subtract, WIDTH=11, a={0,A}, b={1,~B}, cin=1 (sum MSB is 1 when A<B):
   - A=36, B=33 → sum=0x003, MSB=0.
   - A=1, B=0 → sum=0x001.
   - A=12, B=35 → sum=0x7E9, MSB=1.
6. Pipelining: change a/b every cycle over 16 random vectors → each output equals the reference result of the previous cycle's inputs. Assert reset mid-sequence → outputs clear at once, and the stream resumes one edge after release.
